// File: rtl/flash_fetch_ctrl.sv
// Serial-flash line fetch sequencer: issues an SPI mode-0 READ (0x03) plus a 24-bit
// address, deserialises LINE_WORDS words MSB first and writes them to consecutive SRAM words.
module flash_fetch_ctrl #(
    parameter int DATA_W     = 32,
    parameter int SRAM_AW    = 10,
    parameter int LINE_WORDS = 4,
    parameter int SCK_DIV    = 2,
    parameter int CS_HOLD    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [23:0]        req_faddr,
    input  logic [SRAM_AW-1:0] req_saddr,
    output logic               busy,
    output logic               done,
    output logic               flash_cs_n,
    output logic               flash_sck,
    output logic               flash_si,
    input  logic               flash_so,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_wdata
);
    localparam int NBITS  = 32 + LINE_WORDS * DATA_W;
    localparam int CNT_W  = $clog2(NBITS + 1);
    localparam int DIV_W  = $clog2(SCK_DIV + 1);
    localparam int DBIT_W = $clog2(DATA_W + 1);
    localparam int HOLD_W = $clog2(CS_HOLD + 1);
    localparam logic [7:0] CMD_READ = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t             state_r,   state_s;
    logic [DIV_W-1:0]   div_r,     div_s;
    logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
    logic [DBIT_W-1:0]  dbit_r,    dbit_s;
    logic [HOLD_W-1:0]  hold_r,    hold_s;
    logic [30:0]        tx_r,      tx_s;
    logic [DATA_W-1:0]  word_r,    word_s;
    logic [SRAM_AW-1:0] waddr_r,   waddr_s;
    logic               cs_n_r,    cs_n_s;
    logic               sck_r,     sck_s;
    logic               si_r,      si_s;
    logic               busy_r,    busy_s;
    logic               done_r,    done_s;
    logic               we_r,      we_s;
    logic [SRAM_AW-1:0] addr_r,    addr_s;
    logic [DATA_W-1:0]  wdata_r,   wdata_s;
    logic               tick_s;
    logic [DATA_W-1:0]  word_sh_s;

    assign tick_s    = (div_r == DIV_W'(SCK_DIV - 1));
    assign word_sh_s = (word_r << 1'b1) | DATA_W'(flash_so);

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_s   = state_r;
        div_s     = div_r;
        bit_cnt_s = bit_cnt_r;
        dbit_s    = dbit_r;
        hold_s    = hold_r;
        tx_s      = tx_r;
        word_s    = word_r;
        waddr_s   = waddr_r;
        cs_n_s    = cs_n_r;
        sck_s     = sck_r;
        si_s      = si_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        we_s      = 1'b0;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        case (state_r)
            S_IDLE: begin
                if (req) begin
                    state_s   = S_CMD;
                    div_s     = {DIV_W{1'b0}};
                    bit_cnt_s = {CNT_W{1'b0}};
                    dbit_s    = {DBIT_W{1'b0}};
                    hold_s    = {HOLD_W{1'b0}};
                    tx_s      = {CMD_READ[6:0], req_faddr};
                    si_s      = CMD_READ[7];
                    word_s    = {DATA_W{1'b0}};
                    waddr_s   = req_saddr;
                    cs_n_s    = 1'b0;
                    sck_s     = 1'b0;
                    busy_s    = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (tick_s) begin
                    div_s = {DIV_W{1'b0}};
                    sck_s = ~sck_r;
                    if (!sck_r) begin
                        // SCK about to rise: this edge samples flash_so and closes a bit slot
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                        if (state_r == S_CMD && bit_cnt_r == CNT_W'(7)) begin
                            state_s = S_ADDR;
                        end else if (state_r == S_ADDR && bit_cnt_r == CNT_W'(31)) begin
                            state_s = S_DATA;
                        end else if (state_r == S_DATA) begin
                            word_s = word_sh_s;
                            if (dbit_r == DBIT_W'(DATA_W - 1)) begin
                                dbit_s  = {DBIT_W{1'b0}};
                                we_s    = 1'b1;
                                addr_s  = waddr_r;
                                wdata_s = word_sh_s;
                                waddr_s = waddr_r + SRAM_AW'(1);
                            end else begin
                                dbit_s = dbit_r + DBIT_W'(1);
                            end
                        end else begin
                            state_s = state_r;
                        end
                    end else if (state_r == S_DATA && bit_cnt_r == CNT_W'(NBITS)) begin
                        state_s = S_HOLD;
                        cs_n_s  = 1'b1;
                        si_s    = 1'b0;
                        hold_s  = {HOLD_W{1'b0}};
                    end else begin
                        // SCK falling: present the next outgoing bit; zeros once the address is out
                        tx_s = tx_r << 1'b1;
                        si_s = tx_r[30];
                    end
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (hold_r == HOLD_W'(CS_HOLD)) begin
                    state_s = S_IDLE;
                    busy_s  = 1'b0;
                    hold_s  = {HOLD_W{1'b0}};
                end else if (hold_r == HOLD_W'(CS_HOLD - 1)) begin
                    done_s = 1'b1;
                    hold_s = hold_r + HOLD_W'(1);
                end else begin
                    hold_s = hold_r + HOLD_W'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                cs_n_s  = 1'b1;
                sck_s   = 1'b0;
                si_s    = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset to idle pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            div_r     <= {DIV_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            dbit_r    <= {DBIT_W{1'b0}};
            hold_r    <= {HOLD_W{1'b0}};
            tx_r      <= {31{1'b0}};
            word_r    <= {DATA_W{1'b0}};
            waddr_r   <= {SRAM_AW{1'b0}};
            cs_n_r    <= 1'b1;
            sck_r     <= 1'b0;
            si_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= {SRAM_AW{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_s;
            div_r     <= div_s;
            bit_cnt_r <= bit_cnt_s;
            dbit_r    <= dbit_s;
            hold_r    <= hold_s;
            tx_r      <= tx_s;
            word_r    <= word_s;
            waddr_r   <= waddr_s;
            cs_n_r    <= cs_n_s;
            sck_r     <= sck_s;
            si_r      <= si_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            we_r      <= we_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign flash_cs_n = cs_n_r;
    assign flash_sck  = sck_r;
    assign flash_si   = si_r;
    assign sram_we    = we_r;
    assign sram_addr  = addr_r;
    assign sram_wdata = wdata_r;

endmodule

// File: tb/tb_flash_fetch_ctrl.sv
// Bench for flash_fetch_ctrl: behavioural SPI flash models, event recorders and
// directed/randomised fetch scenarios compared against spec-level expectations.
module tb_flash_fetch_ctrl;
    localparam int DW = 32, AW = 10, LW = 4, DIV = 2, HOLD = 4;
    localparam int DIV2 = 1, LW2 = 1;

    logic clk = 1'b0, rst = 1'b1;
    logic req = 1'b0;  logic [23:0] req_faddr = 24'h0;  logic [AW-1:0] req_saddr = 10'h0;
    logic busy, done, flash_cs_n, flash_sck, flash_si, sram_we;
    logic flash_so = 1'b0;
    logic [AW-1:0] sram_addr;  logic [DW-1:0] sram_wdata;

    logic req2 = 1'b0; logic [23:0] req2_faddr = 24'h0; logic [AW-1:0] req2_saddr = 10'h0;
    logic busy2, done2, cs2_n, sck2, si2, we2;
    logic so2 = 1'b0;
    logic [AW-1:0] addr2;  logic [DW-1:0] wdata2;

    int total = 0, bad = 0, cyc = 0;

    flash_fetch_ctrl #(.DATA_W(DW), .SRAM_AW(AW), .LINE_WORDS(LW), .SCK_DIV(DIV), .CS_HOLD(HOLD)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_faddr(req_faddr), .req_saddr(req_saddr),
        .busy(busy), .done(done), .flash_cs_n(flash_cs_n), .flash_sck(flash_sck),
        .flash_si(flash_si), .flash_so(flash_so), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata));

    flash_fetch_ctrl #(.DATA_W(DW), .SRAM_AW(AW), .LINE_WORDS(LW2), .SCK_DIV(DIV2), .CS_HOLD(HOLD)) u_dut2 (
        .clk(clk), .rst(rst), .req(req2), .req_faddr(req2_faddr), .req_saddr(req2_saddr),
        .busy(busy2), .done(done2), .flash_cs_n(cs2_n), .flash_sck(sck2),
        .flash_si(si2), .flash_so(so2), .sram_we(we2), .sram_addr(addr2),
        .sram_wdata(wdata2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash model and recorder for the default instance
    logic [127:0] fl_line = 128'h0;
    int rc = 0, cs_hi = 0, si_bad = 0;
    logic sck_q = 1'b0, cs_q = 1'b1, si_prev = 1'b0;
    logic [31:0] si_acc = 32'h0;
    int c0_q[$], done_q[$], gap_q[$], wr_cyc_q[$];
    logic [31:0] si_q[$], wr_data_q[$];
    logic [AW-1:0] wr_addr_q[$];

    always @(negedge clk) begin
        if (flash_cs_n) begin
            rc = 0; cs_hi = cs_hi + 1; flash_so = 1'b0;
        end else begin
            if (cs_q) begin c0_q.push_back(cyc); gap_q.push_back(cs_hi); end
            cs_hi = 0;
            if (flash_sck && sck_q && flash_si !== si_prev) si_bad = si_bad + 1;
            if (flash_sck && !sck_q) begin
                if (rc < 32) si_acc = {si_acc[30:0], flash_si};
                rc = rc + 1;
                if (rc == 32) si_q.push_back(si_acc);
            end else if (!flash_sck && sck_q && rc >= 32 && rc - 32 < 128) begin
                flash_so = fl_line[127 - (rc - 32)];
            end
        end
        if (sram_we) begin wr_addr_q.push_back(sram_addr); wr_data_q.push_back(sram_wdata); wr_cyc_q.push_back(cyc); end
        if (done) done_q.push_back(cyc);
        sck_q = flash_sck; cs_q = flash_cs_n; si_prev = flash_si;
    end

    // Flash model and recorder for the SCK_DIV=1, LINE_WORDS=1 instance
    logic [31:0] fl2_word = 32'h0;
    int rc2 = 0;
    logic sck2_q = 1'b0, cs2_q = 1'b1;
    logic [31:0] si2_acc = 32'h0;
    int c02_q[$], done2_q[$], rise2_q[$];
    logic [31:0] si2_q[$], wr2_data_q[$];
    logic [AW-1:0] wr2_addr_q[$];

    always @(negedge clk) begin
        if (cs2_n) begin
            rc2 = 0; so2 = 1'b0;
        end else begin
            if (cs2_q) c02_q.push_back(cyc);
            if (sck2 && !sck2_q) begin
                rise2_q.push_back(cyc);
                if (rc2 < 32) si2_acc = {si2_acc[30:0], si2};
                rc2 = rc2 + 1;
                if (rc2 == 32) si2_q.push_back(si2_acc);
            end else if (!sck2 && sck2_q && rc2 >= 32 && rc2 - 32 < 32) begin
                so2 = fl2_word[31 - (rc2 - 32)];
            end
        end
        if (we2) begin wr2_addr_q.push_back(addr2); wr2_data_q.push_back(wdata2); end
        if (done2) done2_q.push_back(cyc);
        sck2_q = sck2; cs2_q = cs2_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_fetch(input logic [23:0] fa, input logic [AW-1:0] sa);
        req_faddr = fa; req_saddr = sa; req = 1'b1;
        for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
        chk("accept", busy, 1);
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 1);
    endtask

    // Expected behaviour of one fetch derived from request and flash contents
    task automatic check_fetch(input string tag, input int wb, input int cb, input int dn, input int sb,
                               input logic [23:0] fa, input logic [AW-1:0] sa, input logic [127:0] line);
        logic [127:0] t;
        if (sb < si_q.size()) chk({tag, "_si"}, si_q[sb], {8'h03, fa});
        else chk({tag, "_si_count"}, si_q.size(), sb + 1);
        for (int k = 0; k < LW; k++) begin
            if (wb + k < wr_addr_q.size()) begin
                t = line >> (32 * (LW - 1 - k));
                chk($sformatf("%s_addr%0d", tag, k), wr_addr_q[wb + k], (int'(sa) + k) % (1 << AW));
                chk($sformatf("%s_data%0d", tag, k), wr_data_q[wb + k], t[31:0]);
            end
        end
        if (dn < done_q.size() && cb < c0_q.size()) begin
            chk({tag, "_latency"}, done_q[dn] - c0_q[cb], 2 * DIV * (32 + LW * DW) + HOLD);
            if (wb + LW - 1 < wr_cyc_q.size())
                chk({tag, "_last_we_before_done"}, wr_cyc_q[wb + LW - 1] < done_q[dn], 1);
        end else begin
            chk({tag, "_done_record"}, done_q.size(), dn + 1);
        end
    endtask

    initial begin
        logic [127:0] la, lb;
        logic [23:0] fa, fb;
        logic [AW-1:0] sa, sb_;
        int wb, cb, dn, sb;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_pins", {flash_cs_n, flash_sck, flash_si, busy, done, sram_we}, 6'b100000);
        chk("reset_addr", sram_addr, 0);
        chk("reset_wdata", sram_wdata, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single directed fetch
        fl_line = 128'h11223344_55667788_99AABBCC_DDEEFF00;
        wb = wr_addr_q.size(); cb = c0_q.size(); dn = done_q.size(); sb = si_q.size();
        start_fetch(24'h000100, 10'h3F0);
        wait_done("single");
        @(negedge clk);
        chk("single_busy_after_done", busy, 0);
        repeat (3) @(negedge clk);
        chk("single_nwr", wr_addr_q.size() - wb, LW);
        chk("single_ndone", done_q.size() - dn, 1);
        check_fetch("single", wb, cb, dn, sb, 24'h000100, 10'h3F0, fl_line);

        // address wrap with random data
        la = {$urandom, $urandom, $urandom, $urandom}; fa = 24'($urandom);
        fl_line = la;
        wb = wr_addr_q.size(); cb = c0_q.size(); dn = done_q.size(); sb = si_q.size();
        start_fetch(fa, 10'h3FE);
        wait_done("wrap");
        repeat (4) @(negedge clk);
        chk("wrap_nwr", wr_addr_q.size() - wb, LW);
        check_fetch("wrap", wb, cb, dn, sb, fa, 10'h3FE, la);

        // ignored request while busy, then back-to-back re-accept
        la = {$urandom, $urandom, $urandom, $urandom}; fa = 24'($urandom); sa = 10'($urandom);
        lb = {$urandom, $urandom, $urandom, $urandom}; fb = 24'($urandom); sb_ = 10'($urandom);
        fl_line = la;
        wb = wr_addr_q.size(); cb = c0_q.size(); dn = done_q.size(); sb = si_q.size();
        start_fetch(fa, sa);
        for (int i = 0; i < 3000 && wr_addr_q.size() < wb + 1; i++) @(negedge clk);
        chk("b2b_mid_data", wr_addr_q.size() - wb, 1);
        req_faddr = ~fa; req_saddr = sa ^ 10'h155; req = 1'b1;
        repeat (3) @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        req_faddr = fb; req_saddr = sb_; req = 1'b1;
        wait_done("b2b_first");
        fl_line = lb;
        @(negedge clk);
        chk("b2b_idle_gap", busy, 0);
        @(negedge clk);
        chk("b2b_reaccept", busy, 1);
        req = 1'b0;
        wait_done("b2b_second");
        repeat (3) @(negedge clk);
        chk("b2b_nwr", wr_addr_q.size() - wb, 2 * LW);
        check_fetch("b2b_a", wb, cb, dn, sb, fa, sa, la);
        check_fetch("b2b_b", wb + LW, cb + 1, dn + 1, sb + 1, fb, sb_, lb);
        if (cb + 1 < c0_q.size() && dn < done_q.size()) begin
            chk("b2b_cs_gap", gap_q[cb + 1] >= HOLD, 1);
            chk("b2b_restart_cycle", c0_q[cb + 1] - done_q[dn], 2);
        end else begin
            chk("b2b_c0_record", c0_q.size(), cb + 2);
        end

        // reset in the middle of DATA after two words
        la = {$urandom, $urandom, $urandom, $urandom}; fa = 24'($urandom); sa = 10'($urandom);
        fl_line = la;
        wb = wr_addr_q.size(); dn = done_q.size();
        start_fetch(fa, sa);
        for (int i = 0; i < 3000 && wr_addr_q.size() < wb + 2; i++) @(negedge clk);
        chk("rst_two_words", wr_addr_q.size() - wb, 2);
        repeat (5) @(negedge clk);
        chk("rst_cs_low_before", flash_cs_n, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_pins", {flash_cs_n, flash_sck, flash_si, busy, done, sram_we}, 6'b100000);
        chk("rst_async_addr", sram_addr, 0);
        chk("rst_async_wdata", sram_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (700) @(negedge clk);
        chk("rst_no_more_we", wr_addr_q.size() - wb, 2);
        chk("rst_no_done", done_q.size() - dn, 0);
        la = {$urandom, $urandom, $urandom, $urandom}; fa = 24'($urandom); sa = 10'($urandom);
        fl_line = la;
        wb = wr_addr_q.size(); cb = c0_q.size(); dn = done_q.size(); sb = si_q.size();
        start_fetch(fa, sa);
        wait_done("after_rst");
        repeat (3) @(negedge clk);
        chk("after_rst_nwr", wr_addr_q.size() - wb, LW);
        check_fetch("after_rst", wb, cb, dn, sb, fa, sa, la);
        chk("si_stable_while_sck_high", si_bad, 0);

        // SCK_DIV=1, LINE_WORDS=1 instance
        fl2_word = $urandom; fa = 24'($urandom); sa = 10'($urandom);
        req2_faddr = fa; req2_saddr = sa; req2 = 1'b1;
        for (int i = 0; i < 10 && !busy2; i++) @(negedge clk);
        chk("p2_accept", busy2, 1);
        req2 = 1'b0;
        for (int i = 0; i < 1000 && !done2; i++) @(negedge clk);
        chk("p2_done_seen", done2, 1);
        repeat (3) @(negedge clk);
        chk("p2_nwr", wr2_addr_q.size(), 1);
        chk("p2_ndone", done2_q.size(), 1);
        if (wr2_addr_q.size() > 0 && si2_q.size() > 0 && c02_q.size() > 0 && done2_q.size() > 0
            && rise2_q.size() > 1) begin
            chk("p2_addr", wr2_addr_q[0], sa);
            chk("p2_data", wr2_data_q[0], fl2_word);
            chk("p2_si", si2_q[0], {8'h03, fa});
            chk("p2_latency", done2_q[0] - c02_q[0], 2 * DIV2 * (32 + LW2 * DW) + HOLD);
            chk("p2_first_rise", rise2_q[0] - c02_q[0], DIV2);
            chk("p2_sck_period", rise2_q[1] - rise2_q[0], 2 * DIV2);
        end else begin
            chk("p2_records", 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
